// File: rtl/sdram_pkg.sv
// Shared types, pin encodings and mode-register helpers for the SDRAM PHY front end.
package sdram_pkg;

    typedef enum logic [3:0] {
        CmdNop          = 4'd0,
        CmdActive       = 4'd1,
        CmdRead         = 4'd2,
        CmdWrite        = 4'd3,
        CmdPrechargeAll = 4'd4,
        CmdAutoRefresh  = 4'd5,
        CmdSelfRefresh  = 4'd6,
        CmdLoadMode     = 4'd7,
        CmdSrExit       = 4'd8
    } sdram_cmd_t;

    typedef enum logic [1:0] {
        StIdle,
        StWriteBurst,
        StReadWait,
        StSelfRef
    } phy_state_e;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] PinsNop       = 4'b0111;
    localparam logic [3:0] PinsActive    = 4'b0011;
    localparam logic [3:0] PinsRead      = 4'b0101;
    localparam logic [3:0] PinsWrite     = 4'b0100;
    localparam logic [3:0] PinsPrecharge = 4'b0010;
    localparam logic [3:0] PinsRefresh   = 4'b0001;
    localparam logic [3:0] PinsLoadMode  = 4'b0000;

    function automatic logic [2:0] bl_code(input int unsigned burst_len);
        case (burst_len)
            2:       return 3'd1;
            4:       return 3'd2;
            8:       return 3'd3;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [6:0] mode_word(input int unsigned cas_lat,
                                             input int unsigned burst_len);
        return {3'(cas_lat), 1'b0, bl_code(burst_len)};
    endfunction

endpackage

// File: rtl/sdram_rd_capture.sv
// Read-data capture: delays the per-beat read tag by CAS latency, then registers dq_in.
module sdram_rd_capture
    import sdram_pkg::*;
#(
    parameter int unsigned DQ_W    = 32,
    parameter int unsigned CAS_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_tag,
    input  logic [DQ_W-1:0] dq_in,
    output logic [DQ_W-1:0] rdata,
    output logic            rdata_valid
);

    logic [CAS_LAT-1:0] tag_q;
    logic [DQ_W-1:0]    rdata_q;
    logic               rdata_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            tag_q         <= {tag_q[CAS_LAT-2:0], rd_tag};
            rdata_valid_q <= tag_q[CAS_LAT-1];
            // Data is only updated on a real beat so rdata holds between bursts.
            if (tag_q[CAS_LAT-1]) begin
                rdata_q <= dq_in;
            end
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;

endmodule

// File: rtl/sdram_phy_if.sv
// SDRAM command/data front end: one controller command per handshake to registered pin states.
module sdram_phy_if
    import sdram_pkg::*;
#(
    parameter int unsigned ROW_W     = 13,
    parameter int unsigned COL_W     = 10,
    parameter int unsigned BANK_W    = 2,
    parameter int unsigned DQ_W      = 32,
    parameter int unsigned CAS_LAT   = 3,
    parameter int unsigned BURST_LEN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3:0]          cmd,
    input  logic                cmd_ap,
    input  logic [BANK_W-1:0]   bank,
    input  logic [ROW_W-1:0]    row_addr,
    input  logic [COL_W-1:0]    col_addr,
    input  logic [DQ_W-1:0]     wdata,
    output logic                wdata_req,
    output logic [DQ_W-1:0]     rdata,
    output logic                rdata_valid,
    output logic                cmd_err,
    output logic                cke,
    output logic                cs_n,
    output logic                ras_n,
    output logic                cas_n,
    output logic                we_n,
    output logic [BANK_W-1:0]   ba,
    output logic [ROW_W-1:0]    addr,
    output logic [DQ_W/8-1:0]   dqm,
    output logic [DQ_W-1:0]     dq_out,
    output logic                dq_oe,
    input  logic [DQ_W-1:0]     dq_in
);

    localparam int unsigned DqmW  = DQ_W / 8;
    localparam int unsigned BeatW = $clog2(BURST_LEN) + 1;

    phy_state_e         state_q;
    logic [BeatW-1:0]   beat_cnt_q;
    logic [1:0]         lat_cnt_q;
    logic [3:0]         pins_q;
    logic               cke_q;
    logic [BANK_W-1:0]  ba_q;
    logic [ROW_W-1:0]   addr_q;
    logic [DqmW-1:0]    dqm_q;
    logic [DQ_W-1:0]    dq_out_q;
    logic               dq_oe_q;
    logic               wdata_req_q;
    logic               cmd_err_q;
    logic               cmd_ready_q;
    logic               rd_tag_q;

    logic               accept;
    logic [ROW_W-1:0]   rw_addr;
    logic [ROW_W-1:0]   pre_addr;
    logic [ROW_W-1:0]   mode_addr;

    assign accept    = cmd_valid && cmd_ready_q;
    assign mode_addr = ROW_W'(mode_word(CAS_LAT, BURST_LEN));

    always_comb begin
        rw_addr                = '0;
        rw_addr[COL_W-1:0]     = col_addr;
        rw_addr[10]            = cmd_ap;
        pre_addr               = '0;
        pre_addr[10]           = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            pins_q      <= PinsNop;
            cke_q       <= 1'b1;
            ba_q        <= '0;
            addr_q      <= '0;
            dqm_q       <= '1;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            wdata_req_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            rd_tag_q    <= 1'b0;
        end else begin
            pins_q      <= PinsNop;
            cke_q       <= 1'b1;
            ba_q        <= '0;
            addr_q      <= '0;
            dqm_q       <= '1;
            dq_oe_q     <= 1'b0;
            wdata_req_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            rd_tag_q    <= 1'b0;

            case (state_q)
                StIdle: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        case (cmd)
                            CmdNop, CmdSrExit: begin
                            end
                            CmdActive: begin
                                pins_q <= PinsActive;
                                addr_q <= row_addr;
                                ba_q   <= bank;
                            end
                            CmdRead: begin
                                pins_q      <= PinsRead;
                                addr_q      <= rw_addr;
                                ba_q        <= bank;
                                dqm_q       <= '0;
                                rd_tag_q    <= 1'b1;
                                beat_cnt_q  <= BeatW'(1);
                                lat_cnt_q   <= '0;
                                cmd_ready_q <= 1'b0;
                                state_q     <= StReadWait;
                            end
                            CmdWrite: begin
                                pins_q   <= PinsWrite;
                                addr_q   <= rw_addr;
                                ba_q     <= bank;
                                dqm_q    <= '0;
                                dq_oe_q  <= 1'b1;
                                dq_out_q <= wdata;
                                if (BURST_LEN > 1) begin
                                    wdata_req_q <= 1'b1;
                                    beat_cnt_q  <= BeatW'(1);
                                    cmd_ready_q <= 1'b0;
                                    state_q     <= StWriteBurst;
                                end
                            end
                            CmdPrechargeAll: begin
                                pins_q <= PinsPrecharge;
                                addr_q <= pre_addr;
                            end
                            CmdAutoRefresh: begin
                                pins_q <= PinsRefresh;
                            end
                            CmdSelfRefresh: begin
                                pins_q  <= PinsRefresh;
                                cke_q   <= 1'b0;
                                state_q <= StSelfRef;
                            end
                            CmdLoadMode: begin
                                pins_q <= PinsLoadMode;
                                addr_q <= mode_addr;
                            end
                            default: begin
                                cmd_err_q <= 1'b1;
                            end
                        endcase
                    end
                end

                // beat_cnt_q is the index of the beat whose wdata is on the bus this cycle.
                StWriteBurst: begin
                    dqm_q      <= '0;
                    dq_oe_q    <= 1'b1;
                    dq_out_q   <= wdata;
                    beat_cnt_q <= beat_cnt_q + BeatW'(1);
                    if (beat_cnt_q == BeatW'(BURST_LEN - 1)) begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        wdata_req_q <= 1'b1;
                    end
                end

                // First the dqm/tag window for every beat, then wait out CAS latency.
                StReadWait: begin
                    if (beat_cnt_q < BeatW'(BURST_LEN)) begin
                        dqm_q      <= '0;
                        rd_tag_q   <= 1'b1;
                        beat_cnt_q <= beat_cnt_q + BeatW'(1);
                    end else if (lat_cnt_q == 2'(CAS_LAT - 1)) begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 2'd1;
                    end
                end

                StSelfRef: begin
                    cmd_ready_q <= 1'b1;
                    cke_q       <= 1'b0;
                    if (accept) begin
                        if (cmd == CmdSrExit) begin
                            cke_q   <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    sdram_rd_capture #(
        .DQ_W    (DQ_W),
        .CAS_LAT (CAS_LAT)
    ) u_rd_capture (
        .clk         (clk),
        .rst         (rst),
        .rd_tag      (rd_tag_q),
        .dq_in       (dq_in),
        .rdata       (rdata),
        .rdata_valid (rdata_valid)
    );

    assign {cs_n, ras_n, cas_n, we_n} = pins_q;
    assign cke       = cke_q;
    assign ba        = ba_q;
    assign addr      = addr_q;
    assign dqm       = dqm_q;
    assign dq_out    = dq_out_q;
    assign dq_oe     = dq_oe_q;
    assign wdata_req = wdata_req_q;
    assign cmd_err   = cmd_err_q;
    assign cmd_ready = cmd_ready_q;

endmodule

// File: tb/tb_sdram_phy_if.sv
// Bench for sdram_phy_if: directed steps then random commands against a per-cycle pin model.
module tb_sdram_phy_if;

    localparam int unsigned ROW_W     = 13;
    localparam int unsigned COL_W     = 10;
    localparam int unsigned BANK_W    = 2;
    localparam int unsigned DQ_W      = 32;
    localparam int unsigned CAS_LAT   = 3;
    localparam int unsigned BURST_LEN = 4;
    localparam int N = 2048;

    logic tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    logic              rst, cmd_valid, cmd_ready, cmd_ap, wdata_req, rdata_valid, cmd_err;
    logic [3:0]        cmd;
    logic [BANK_W-1:0] bank, ba;
    logic [ROW_W-1:0]  row_addr, addr;
    logic [COL_W-1:0]  col_addr;
    logic [DQ_W-1:0]   wdata, rdata, dq_out, dq_in;
    logic              cke, cs_n, ras_n, cas_n, we_n, dq_oe;
    logic [DQ_W/8-1:0] dqm;

    sdram_phy_if #(
        .ROW_W     (ROW_W),
        .COL_W     (COL_W),
        .BANK_W    (BANK_W),
        .DQ_W      (DQ_W),
        .CAS_LAT   (CAS_LAT),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clk         (tb_clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd         (cmd),
        .cmd_ap      (cmd_ap),
        .bank        (bank),
        .row_addr    (row_addr),
        .col_addr    (col_addr),
        .wdata       (wdata),
        .wdata_req   (wdata_req),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .cmd_err     (cmd_err),
        .cke         (cke),
        .cs_n        (cs_n),
        .ras_n       (ras_n),
        .cas_n       (cas_n),
        .we_n        (we_n),
        .ba          (ba),
        .addr        (addr),
        .dqm         (dqm),
        .dq_out      (dq_out),
        .dq_oe       (dq_oe),
        .dq_in       (dq_in)
    );

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    string phase = "reset";

    // Reference model state: expected pin picture for every absolute cycle.
    int ready_from = 0;
    bit sr = 1'b0;
    bit wr_on = 1'b0;
    int wr_t = 0;
    bit fixed_rd = 1'b0;

    logic [3:0]  e_pins [N];
    bit          e_cke [N];
    logic [1:0]  e_ba [N];
    logic [12:0] e_addr [N];
    bit          e_dqm0 [N];
    bit          e_oe [N];
    bit          e_dqchk [N];
    bit          e_wreq [N];
    bit          e_err [N];
    bit          e_rv [N];
    bit          e_rchk [N];
    bit          e_dqin_v [N];
    logic [31:0] e_dq [N];
    logic [31:0] e_rd [N];
    logic [31:0] e_dqin [N];
    logic [3:0]  cmd_tbl [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s:%s cycle %0d observed %0h expected %0h", phase, tag, cyc, obs, exp);
        end
    endtask

    task automatic set_idle(input int i);
        e_pins[i]   = 4'b0111;
        e_cke[i]    = 1'b1;
        e_ba[i]     = '0;
        e_addr[i]   = '0;
        e_dqm0[i]   = 1'b0;
        e_oe[i]     = 1'b0;
        e_dqchk[i]  = 1'b0;
        e_wreq[i]   = 1'b0;
        e_err[i]    = 1'b0;
        e_rv[i]     = 1'b0;
        e_rchk[i]   = 1'b0;
        e_dqin_v[i] = 1'b0;
        e_dq[i]     = '0;
        e_rd[i]     = '0;
        e_dqin[i]   = '0;
    endtask

    task automatic check_cycle(input int n);
        chk("pins", {28'd0, cs_n, ras_n, cas_n, we_n}, {28'd0, e_pins[n]});
        chk("cke", {31'd0, cke}, {31'd0, e_cke[n]});
        chk("ba", {30'd0, ba}, {30'd0, e_ba[n]});
        chk("addr", {19'd0, addr}, {19'd0, e_addr[n]});
        chk("dqm", {28'd0, dqm}, e_dqm0[n] ? 32'd0 : 32'hF);
        chk("dq_oe", {31'd0, dq_oe}, {31'd0, e_oe[n]});
        chk("wdata_req", {31'd0, wdata_req}, {31'd0, e_wreq[n]});
        chk("cmd_err", {31'd0, cmd_err}, {31'd0, e_err[n]});
        chk("rdata_valid", {31'd0, rdata_valid}, {31'd0, e_rv[n]});
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, n >= ready_from});
        if (e_oe[n] || e_dqchk[n]) chk("dq_out", dq_out, e_dq[n]);
        if (e_rv[n] || e_rchk[n]) chk("rdata", rdata, e_rd[n]);
    endtask

    task automatic model(input int n, input bit r, input bit v, input logic [3:0] c,
                         input bit ap, input logic [1:0] b, input logic [12:0] ra,
                         input logic [9:0] ca);
        int n1;
        logic [31:0] d;
        n1 = n + 1;
        if (r) begin
            for (int i = n1; i < n1 + 24 && i < N; i++) set_idle(i);
            e_dqchk[n1] = 1'b1;
            e_rchk[n1]  = 1'b1;
            ready_from  = n + 2;
            sr          = 1'b0;
            wr_on       = 1'b0;
            return;
        end
        if (wr_on && n >= wr_t + 1 && n <= wr_t + int'(BURST_LEN) - 1) e_dq[n1] = wdata;
        if (wr_on && n >= wr_t + int'(BURST_LEN) - 1) wr_on = 1'b0;
        if (v && n >= ready_from) begin
            if (sr) begin
                if (c == 4'd8) sr = 1'b0;
                else e_err[n1] = 1'b1;
            end else begin
                case (c)
                    4'd0, 4'd8: begin
                    end
                    4'd1: begin
                        e_pins[n1] = 4'b0011;
                        e_addr[n1] = ra;
                        e_ba[n1]   = b;
                    end
                    4'd2: begin
                        e_pins[n1] = 4'b0101;
                        e_addr[n1] = {2'b00, ap, ca};
                        e_ba[n1]   = b;
                        for (int k = 0; k < int'(BURST_LEN); k++) begin
                            d = fixed_rd ? 32'(k + 1) : $urandom;
                            e_dqm0[n1 + k] = 1'b1;
                            e_dqin_v[n + 1 + int'(CAS_LAT) + k] = 1'b1;
                            e_dqin[n + 1 + int'(CAS_LAT) + k]   = d;
                            e_rv[n + 2 + int'(CAS_LAT) + k]     = 1'b1;
                            e_rd[n + 2 + int'(CAS_LAT) + k]     = d;
                        end
                        ready_from = n + int'(CAS_LAT) + int'(BURST_LEN);
                    end
                    4'd3: begin
                        e_pins[n1] = 4'b0100;
                        e_addr[n1] = {2'b00, ap, ca};
                        e_ba[n1]   = b;
                        e_dq[n1]   = wdata;
                        for (int k = 0; k < int'(BURST_LEN); k++) begin
                            e_dqm0[n1 + k] = 1'b1;
                            e_oe[n1 + k]   = 1'b1;
                        end
                        for (int k = 1; k < int'(BURST_LEN); k++) e_wreq[n + k] = 1'b1;
                        wr_on      = 1'b1;
                        wr_t       = n;
                        ready_from = n + int'(BURST_LEN);
                    end
                    4'd4: begin
                        e_pins[n1] = 4'b0010;
                        e_addr[n1] = 13'h400;
                    end
                    4'd5: e_pins[n1] = 4'b0001;
                    4'd6: begin
                        e_pins[n1] = 4'b0001;
                        sr = 1'b1;
                    end
                    4'd7: begin
                        e_pins[n1] = 4'b0000;
                        e_addr[n1] = 13'(CAS_LAT * 16 + $clog2(BURST_LEN));
                    end
                    default: e_err[n1] = 1'b1;
                endcase
            end
        end
        e_cke[n1] = !sr;
    endtask

    task automatic step(input bit r, input bit v, input logic [3:0] c, input bit ap,
                        input logic [1:0] b, input logic [12:0] ra, input logic [9:0] ca);
        int n;
        n = cyc;
        @(negedge tb_clk);
        if (n > 0) check_cycle(n);
        rst       = r;
        cmd_valid = v;
        cmd       = c;
        cmd_ap    = ap;
        bank      = b;
        row_addr  = ra;
        col_addr  = ca;
        wdata     = $urandom;
        dq_in     = e_dqin_v[n] ? e_dqin[n] : $urandom;
        model(n, r, v, c, ap, b, ra, ca);
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 13'd0, 10'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_idle(i);
        cmd_tbl = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd3, 4'd1, 4'd4, 4'd5,
                    4'd7, 4'd0, 4'd8, 4'd6, 4'd9, 4'd13, 4'd15, 4'd2};
        rst = 1'b1; cmd_valid = 1'b0; cmd = '0; cmd_ap = 1'b0; bank = '0;
        row_addr = '0; col_addr = '0; wdata = '0; dq_in = '0;

        phase = "reset";
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 13'd0, 10'd0);
        idle(2);

        phase = "active";
        step(1'b0, 1'b1, 4'd1, 1'b0, 2'd3, 13'h15A3, 10'd0);
        idle(2);

        phase = "write";
        step(1'b0, 1'b1, 4'd3, 1'b1, 2'd2, 13'd0, 10'd20);
        idle(6);

        phase = "read";
        fixed_rd = 1'b1;
        step(1'b0, 1'b1, 4'd2, 1'b0, 2'd1, 13'd0, 10'h2FF);
        idle(10);
        fixed_rd = 1'b0;

        phase = "load_mode";
        step(1'b0, 1'b1, 4'd7, 1'b0, 2'd0, 13'd0, 10'd0);
        idle(2);

        phase = "precharge_refresh";
        step(1'b0, 1'b1, 4'd4, 1'b0, 2'd1, 13'h1FFF, 10'h3FF);
        step(1'b0, 1'b1, 4'd5, 1'b0, 2'd0, 13'd0, 10'd0);
        step(1'b0, 1'b1, 4'd11, 1'b0, 2'd0, 13'd0, 10'd0);
        idle(2);

        phase = "self_refresh";
        step(1'b0, 1'b1, 4'd6, 1'b0, 2'd0, 13'd0, 10'd0);
        idle(3);
        step(1'b0, 1'b1, 4'd1, 1'b0, 2'd3, 13'h0AAA, 10'd0);
        idle(2);
        step(1'b0, 1'b1, 4'd8, 1'b0, 2'd0, 13'd0, 10'd0);
        idle(3);

        phase = "random";
        for (int i = 0; i < 600; i++) begin
            bit v;
            logic [3:0] c;
            c = cmd_tbl[$urandom_range(0, 15)];
            v = (cyc >= ready_from) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step(1'b0, v, c, 1'($urandom), 2'($urandom), 13'($urandom), 10'($urandom));
        end
        idle(12);

        phase = "reset_mid_read";
        step(1'b0, 1'b1, 4'd8, 1'b0, 2'd0, 13'd0, 10'd0);
        idle(2);
        step(1'b0, 1'b1, 4'd2, 1'b1, 2'd2, 13'd0, 10'h155);
        idle(4);
        step(1'b1, 1'b0, 4'd0, 1'b0, 2'd0, 13'd0, 10'd0);
        idle(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
